// File: rtl/crc_engine.sv
// crc_engine: parametrised CRC over a byte stream, BITS_PER_CYCLE bits folded per clock,
// reporting the final CRC and a residue match at every frame end.
module crc_engine #(
   parameter int                   CRC_WIDTH      = 8,
   parameter logic [CRC_WIDTH-1:0] POLYNOMIAL     = 8'h07,
   parameter logic [CRC_WIDTH-1:0] INIT           = '0,
   parameter logic [CRC_WIDTH-1:0] XOR_OUT        = '0,
   parameter bit                   REFLECT_IN     = 1'b0,
   parameter bit                   REFLECT_OUT    = 1'b0,
   parameter logic [CRC_WIDTH-1:0] RESIDUE        = '0,
   parameter int                   BITS_PER_CYCLE = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [7:0]           data_i,
   input  logic                 data_valid_i,
   input  logic                 data_last_i,
   output logic                 data_ready_o,
   output logic [CRC_WIDTH-1:0] crc_o,
   output logic                 crc_valid_o,
   output logic                 crc_match_o
);
   localparam logic [0:0] ACCEPT = 1'b0;
   localparam logic [0:0] SHIFT  = 1'b1;
   if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_bpc
      $error("crc_engine: BITS_PER_CYCLE must be 1, 2, 4 or 8");
   end
   function automatic logic [7:0] rev8(input logic [7:0] b);
      for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
   endfunction
   function automatic logic [CRC_WIDTH-1:0] rev_crc(input logic [CRC_WIDTH-1:0] r);
      for (int i = 0; i < CRC_WIDTH; i++) rev_crc[i] = r[CRC_WIDTH-1-i];
   endfunction
   // Bits are consumed MSB first, matching a one-bit-per-clock serial LFSR.
   function automatic logic [CRC_WIDTH-1:0] fold(input logic [CRC_WIDTH-1:0] r, input logic [BITS_PER_CYCLE-1:0] b);
      logic [CRC_WIDTH-1:0] x;
      x = r;
      for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) x = (x << 1) ^ ((x[CRC_WIDTH-1] ^ b[i]) ? POLYNOMIAL : '0);
      return x;
   endfunction
   logic [0:0]           state_q;
   logic [CRC_WIDTH-1:0] crc_q, crc_d;
   logic [7:0]           buf_q, byte_in;
   logic [2:0]           cnt_q;
   logic                 start_q, last_q, valid_q, match_q, take, shift, fin;
   assign data_ready_o = state_q == ACCEPT;
   assign take         = data_ready_o && data_valid_i;
   assign shift        = state_q == SHIFT;
   assign byte_in      = REFLECT_IN ? rev8(data_i) : data_i;
   assign fin          = (BITS_PER_CYCLE == 8) ? take && data_last_i : shift && cnt_q == 3'd1 && last_q;
   assign crc_d        = fold(take ? (start_q ? INIT : crc_q) : crc_q,
                              take ? byte_in[7 -: BITS_PER_CYCLE] : buf_q[7 -: BITS_PER_CYCLE]);
   assign crc_o        = (REFLECT_OUT ? rev_crc(crc_q) : crc_q) ^ XOR_OUT;
   assign crc_valid_o  = valid_q;
   assign crc_match_o  = match_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ACCEPT;
         crc_q   <= INIT;
         buf_q   <= '0;
         cnt_q   <= '0;
         start_q <= 1'b1;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         match_q <= 1'b0;
      end else begin
         valid_q <= fin;
         match_q <= fin && crc_d == RESIDUE;
         if (take || shift) crc_q <= crc_d;
         if (fin) start_q <= 1'b1;
         else if (take) start_q <= 1'b0;
         if (take) begin
            buf_q  <= byte_in << BITS_PER_CYCLE;
            last_q <= data_last_i;
            if (BITS_PER_CYCLE != 8) begin
               state_q <= SHIFT;
               cnt_q   <= 3'(8 / BITS_PER_CYCLE - 1);
            end
         end else if (shift) begin
            buf_q <= buf_q << BITS_PER_CYCLE;
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_q <= ACCEPT;
         end
      end
   end
endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: five engine configurations driven one at a time; a scoreboard queue
// holds the expected CRC, match flag and latency of each frame end.
module tb_crc_engine;
   typedef struct {
      int          i;
      logic [63:0] c;
      logic        m;
      logic        me;
      int          lat;
      int          acc;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  dat [5];
   logic        val [5];
   logic        lst [5];
   logic        rdy [5];
   logic        cv  [5];
   logic        cm  [5];
   logic [7:0]  c0, c3, c4;
   logic [15:0] c1;
   logic [31:0] c2;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   exp_t        sb [$];
   exp_t        e;
   logic [63:0] nxt_crc;
   logic        nxt_m, nxt_me;
   int          nxt_lat;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   crc_engine u_d8 (.clk_i(clk), .rst_i(rst), .data_i(dat[0]), .data_valid_i(val[0]), .data_last_i(lst[0]),
                    .data_ready_o(rdy[0]), .crc_o(c0), .crc_valid_o(cv[0]), .crc_match_o(cm[0]));
   crc_engine #(.CRC_WIDTH(16), .POLYNOMIAL(16'h1021), .INIT(16'hFFFF)) u_d16 (
                    .clk_i(clk), .rst_i(rst), .data_i(dat[1]), .data_valid_i(val[1]), .data_last_i(lst[1]),
                    .data_ready_o(rdy[1]), .crc_o(c1), .crc_valid_o(cv[1]), .crc_match_o(cm[1]));
   crc_engine #(.CRC_WIDTH(32), .POLYNOMIAL(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
                .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u_d32 (
                    .clk_i(clk), .rst_i(rst), .data_i(dat[2]), .data_valid_i(val[2]), .data_last_i(lst[2]),
                    .data_ready_o(rdy[2]), .crc_o(c2), .crc_valid_o(cv[2]), .crc_match_o(cm[2]));
   crc_engine #(.BITS_PER_CYCLE(1)) u_b1 (.clk_i(clk), .rst_i(rst), .data_i(dat[3]), .data_valid_i(val[3]),
                    .data_last_i(lst[3]), .data_ready_o(rdy[3]), .crc_o(c3), .crc_valid_o(cv[3]), .crc_match_o(cm[3]));
   crc_engine #(.BITS_PER_CYCLE(2)) u_b2 (.clk_i(clk), .rst_i(rst), .data_i(dat[4]), .data_valid_i(val[4]),
                    .data_last_i(lst[4]), .data_ready_o(rdy[4]), .crc_o(c4), .crc_valid_o(cv[4]), .crc_match_o(cm[4]));
   function automatic logic [63:0] crc_of(input int i);
      return i == 0 ? {56'd0, c0} : i == 1 ? {48'd0, c1} : i == 2 ? {32'd0, c2} : i == 3 ? {56'd0, c3} : {56'd0, c4};
   endfunction
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic expect_frame(input logic [63:0] c, input logic m, input logic me, input int lat);
      nxt_crc = c;
      nxt_m   = m;
      nxt_me  = me;
      nxt_lat = lat;
   endtask
   task automatic send(input int i, input logic [7:0] b, input logic l, input int w);
      int n = 0;
      dat[i] = b;
      val[i] = 1'b1;
      lst[i] = l;
      while (!rdy[i] && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (w >= 0) check("ready_wait", n, w);
      if (!rdy[i]) check("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (l) sb.push_back('{i: i, c: nxt_crc, m: nxt_m, me: nxt_me, lat: nxt_lat, acc: cyc});
   endtask
   task automatic msg(input int i, input int w0, input int w, input logic l);
      for (int k = 0; k < 9; k++) send(i, 8'h31 + 8'(k), l && k == 8, k == 0 ? w0 : w);
   endtask
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 5; i++) begin
            if (cv[i]) begin
               if (sb.size() == 0) check("spurious_valid", 1, 0);
               else begin
                  e = sb.pop_front();
                  check("frame_owner", i, e.i);
                  check("crc", crc_of(i), e.c);
                  if (e.me) check("match", cm[i], e.m);
                  check("latency", cyc - e.acc + 1, e.lat);
               end
            end
         end
      end
   end
   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
   initial begin
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         dat[i] = 8'h00;
         val[i] = 1'b0;
         lst[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("reset_ready", rdy[i], 1);
         check("reset_valid", cv[i], 0);
      end
      check("reset_crc16", crc_of(1), 64'hFFFF);
      check("reset_crc32", crc_of(2), 64'h0);
      rst = 1'b0;
      @(negedge clk);
      expect_frame(64'hF4, 1'b0, 1'b0, 1);
      msg(0, 0, 0, 1'b1);
      val[0] = 1'b0;
      expect_frame(64'h29B1, 1'b0, 1'b0, 1);
      msg(1, 0, 0, 1'b1);
      val[1] = 1'b0;
      expect_frame(64'hCBF43926, 1'b0, 1'b0, 1);
      msg(2, 0, 0, 1'b1);
      val[2] = 1'b0;
      msg(0, 0, 0, 1'b0);
      expect_frame(64'h00, 1'b1, 1'b1, 1);
      send(0, 8'hF4, 1'b1, 0);
      msg(0, 0, 0, 1'b0);
      expect_frame(64'h07, 1'b0, 1'b1, 1);
      send(0, 8'hF5, 1'b1, 0);
      val[0] = 1'b0;
      expect_frame(64'hF4, 1'b0, 1'b0, 8);
      msg(3, 0, 7, 1'b1);
      val[3] = 1'b0;
      expect_frame(64'hF4, 1'b0, 1'b0, 4);
      msg(4, 0, 3, 1'b1);
      msg(4, 3, 3, 1'b1);
      send(4, 8'h31, 1'b0, 3);
      val[4] = 1'b0;
      check("mid_byte_busy", rdy[4], 0);
      rst = 1'b1;
      #1;
      check("async_reset_ready", rdy[4], 1);
      check("async_reset_valid", cv[4], 0);
      check("async_reset_crc", crc_of(4), 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_valid", cv[4], 0);
      expect_frame(64'hF4, 1'b0, 1'b0, 4);
      msg(4, 0, 3, 1'b1);
      val[4] = 1'b0;
      repeat (20) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
